// File: rtl/board_pkg.sv
// Shared tic-tac-toe encodings: cell codes, winner codes, FSM states,
// the eight winning lines and the (row,col) -> cell index mapping.
package board_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;
  localparam logic [1:0] CELL_HL    = 2'b11;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REDRAW,
    ST_DONE
  } state_t;

  // Cell indices of the 3 rows, 3 columns and 2 diagonals.
  localparam int LINE_CELLS [8][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  // k = 3*row + col; stays within 4 bits even for the illegal row/col value 3.
  function automatic logic [3:0] cell_idx(input logic [1:0] row, input logic [1:0] col);
    return {1'b0, row, 1'b0} + {2'b00, row} + {2'b00, col};
  endfunction

endpackage

// File: rtl/board_writer_win_checker.sv
// Combinational board evaluator: win flags per player, board-full flag and
// a mask of every cell that lies on a completed line.
module win_checker
  import board_pkg::*;
(
  input  logic [17:0] grid,
  output logic        x_win,
  output logic        o_win,
  output logic        full,
  output logic [8:0]  line_mask
);

  logic [1:0] cell_a;
  logic [1:0] cell_b;
  logic [1:0] cell_c;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    x_win     = 1'b0;
    o_win     = 1'b0;
    full      = 1'b1;
    line_mask = '0;
    cell_a    = CELL_EMPTY;
    cell_b    = CELL_EMPTY;
    cell_c    = CELL_EMPTY;
    for (int k = 0; k < 9; k++) begin
      if (grid[2*k +: 2] == CELL_EMPTY) full = 1'b0;
    end
    for (int l = 0; l < 8; l++) begin
      cell_a = grid[2*LINE_CELLS[l][0] +: 2];
      cell_b = grid[2*LINE_CELLS[l][1] +: 2];
      cell_c = grid[2*LINE_CELLS[l][2] +: 2];
      if (cell_a == cell_b && cell_b == cell_c &&
          cell_a != CELL_EMPTY && cell_a != CELL_HL) begin
        if (cell_a == CELL_X) x_win = 1'b1;
        else                  o_win = 1'b1;
        line_mask[LINE_CELLS[l][0]] = 1'b1;
        line_mask[LINE_CELLS[l][1]] = 1'b1;
        line_mask[LINE_CELLS[l][2]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_writer.sv
// Tic-tac-toe game-state owner: accepts moves, scores the board and requests
// redraws via req/ack. Optional BOARD_WIN_HIGHLIGHT_EN marks winning cells with code 11.
module board_writer
  import board_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        move_valid,
  input  logic [1:0]  move_row,
  input  logic [1:0]  move_col,
  output logic        move_ready,
  output logic        move_err,
  input  logic        new_game,
  output logic [17:0] grid,
  output logic        turn,
  output logic [1:0]  winner,
  output logic        game_over,
  output logic        redraw_req,
  input  logic        redraw_ack
);

  state_t     state;
  logic       toggle_pending;
  logic       x_win;
  logic       o_win;
  logic       full;
  logic [8:0] line_mask;
  logic [3:0] target_idx;
  logic [1:0] target_code;
  logic       move_legal;

  win_checker u_win_checker (
    .grid      (grid),
    .x_win     (x_win),
    .o_win     (o_win),
    .full      (full),
    .line_mask (line_mask)
  );

`ifndef BOARD_WIN_HIGHLIGHT_EN
  logic unused_line_mask;
  assign unused_line_mask = ^line_mask;
`endif

  assign move_ready = (state == ST_IDLE) && !new_game;
  assign game_over  = (winner != WIN_NONE);

  always_comb begin
    target_idx  = cell_idx(move_row, move_col);
    target_code = CELL_EMPTY;
    for (int k = 0; k < 9; k++) begin
      if (target_idx == 4'(k)) target_code = grid[2*k +: 2];
    end
    move_legal = (move_row != 2'd3) && (move_col != 2'd3) && (target_code == CELL_EMPTY);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      grid           <= '0;
      turn           <= 1'b0;
      winner         <= WIN_NONE;
      move_err       <= 1'b0;
      redraw_req     <= 1'b0;
      toggle_pending <= 1'b0;
    end else begin
      move_err <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (new_game) begin
            grid           <= '0;
            turn           <= 1'b0;
            winner         <= WIN_NONE;
            toggle_pending <= 1'b0;
            redraw_req     <= 1'b1;
            state          <= ST_REDRAW;
          end else if (state == ST_IDLE && move_valid) begin
            if (move_legal) begin
              for (int k = 0; k < 9; k++) begin
                if (target_idx == 4'(k)) grid[2*k +: 2] <= turn ? CELL_O : CELL_X;
              end
              toggle_pending <= 1'b1;
              state          <= ST_CHECK;
            end else begin
              move_err <= 1'b1;
            end
          end
        end
        ST_CHECK: begin
          // A completed line outranks a full board.
          if (x_win)      winner <= WIN_X;
          else if (o_win) winner <= WIN_O;
          else if (full)  winner <= WIN_DRAW;
          else            winner <= WIN_NONE;
`ifdef BOARD_WIN_HIGHLIGHT_EN
          for (int k = 0; k < 9; k++) begin
            if (line_mask[k]) grid[2*k +: 2] <= CELL_HL;
          end
`endif
          redraw_req <= 1'b1;
          state      <= ST_REDRAW;
        end
        ST_REDRAW: begin
          if (redraw_ack) begin
            redraw_req     <= 1'b0;
            toggle_pending <= 1'b0;
            if (game_over) begin
              state <= ST_DONE;
            end else begin
              state <= ST_IDLE;
              if (toggle_pending) turn <= ~turn;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/board_writer.md
# board_writer

Game-state owner for the tic-tac-toe display path. It accepts player moves, writes them into the 3×3 board, and alternates turns. It detects win and draw, then requests a redraw through a req/ack handshake. Its `grid` output is the board the grid-to-pixel drawer reads.

## Interface
Parameters:
- none; cell codes, winner codes and state encoding live in the shared package.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge
- `resetn`  in  1  reset, synchronous, active-low
- `move_valid`  in  1  move request, held until accepted
- `move_row`  in  2  row 0–2; 3 is illegal
- `move_col`  in  2  column 0–2; 3 is illegal
- `move_ready`  out  1  block can accept a move this cycle
- `move_err`  out  1  one-cycle pulse: illegal or occupied cell rejected
- `new_game`  in  1  clear board and restart
- `grid`  out  18  packed board; cell (r,c) at bits [2k+1:2k], k=3r+c
- `turn`  out  1  player to move: 0 = X, 1 = O
- `winner`  out  2  00 none, 01 X, 10 O, 11 draw
- `game_over`  out  1  winner != 00
- `redraw_req`  out  1  board changed; held until acknowledged
- `redraw_ack`  in  1  drawer finished; sampled only while `redraw_req`=1

## Operation
- Cell codes:
  - 00 empty
  - 01 X
  - 10 O
  - 11 highlight (only with the configuration macro)
- States:
  - IDLE: wait for a move or new game.
  - CHECK: one cycle, evaluate the board.
  - REDRAW: wait for the drawer's ack.
  - DONE: game over; only `new_game` is honoured.
- `move_ready` = (state==IDLE) && !`new_game`. It is combinational from state.
- IDLE, `move_valid`&&`move_ready`:
  - Legal move (row,col ≤ 2 and cell empty): write the cell with the `turn` code; go to CHECK.
  - Illegal move: pulse `move_err` for one cycle (registered, so it is visible the cycle after acceptance); stay in IDLE; grid unchanged. The requester must drop or change the move.
- CHECK:
  - Evaluate all 8 lines (3 rows, 3 columns, 2 diagonals) and register `winner`.
  - A win takes precedence over a draw, even when the board is full.
  - Draw = all 9 cells non-empty and no line won.
  - Go to REDRAW.
- REDRAW:
  - `redraw_req`=1.
  - On `redraw_ack`=1: go to DONE if `game_over`; otherwise go to IDLE.
  - `turn` toggles only on the REDRAW→IDLE transition that follows a move.
- `new_game` is sampled in IDLE or DONE:
  - grid ← 0, `turn` ← 0, `winner` ← 00; go to REDRAW.
  - The REDRAW→IDLE exit after a new game does not toggle `turn`.
  - `new_game` is ignored in CHECK and REDRAW.
- Simultaneous `new_game` and `move_valid` in IDLE: `new_game` wins; the move is not accepted.

## Timing
- Reset values:
  - state IDLE
  - `grid`=0, `turn`=0, `winner`=00, `game_over`=0
  - `redraw_req`=0, `move_err`=0
- Reset mid-handshake abandons the REDRAW; `redraw_req` drops the next cycle. The drawer redraws on its own reset.
- Move latency, with the move accepted at edge E0:
  - `grid` updated after E0.
  - `winner` valid and `redraw_req`=1 after E1.
  - Earliest ack at E2. After the ack edge, `redraw_req`=0 and `turn` is toggled.
- Minimum move-to-move spacing: 3 cycles.
- `redraw_ack` while `redraw_req`=0 is ignored.
- `redraw_req` never deasserts without an ack, except on reset.

## Configuration
- `BOARD_WIN_HIGHLIGHT_EN` defined:
  - In CHECK, every cell on every winning line is rewritten to code 11 in the same cycle `winner` is registered. All lines are highlighted when the last move completes two.
  - `winner` still reports the player.
- Not defined: code 11 is never produced; `grid` keeps player codes.

## Structure
- Package `board_pkg`:
  - cell codes CELL_EMPTY, CELL_X, CELL_O, CELL_HL
  - winner codes WIN_NONE, WIN_X, WIN_O, WIN_DRAW
  - state enum
  - cell index function k=3r+c
- Sub-module `win_checker`: combinational. Input is the 18-bit grid; outputs are `x_win`, `o_win`, `full`, and a 9-bit `line_mask` of cells on winning lines.
- `board_writer` holds the FSM, grid register and handshake.

## Test plan
- **Opening move:** reset, then move (1,1), ack after 2 cycles → `grid`=0x00100 (cell 4 = 01), `winner`=00, `turn`=1 after the ack.
- **Occupied cell:** after the opening move, O requests (1,1) → `move_err` pulses one cycle; `grid` and `turn` unchanged; `redraw_req` stays 0.
- **Out of range:** move (3,0) → `move_err`=1; no state change.
- **X wins:** X at (0,0),(0,1),(0,2), O at (1,0),(1,1) → `winner`=01, `game_over`=1, state DONE after the ack. A further `move_valid` sees `move_ready`=0. With the macro, bits [5:0]=111111.
- **Draw:** sequence X00,O01,X02,O11,X10,O12,X21,O20,X22 → `winner`=11 after the ninth move; no highlight.
- **New game with held ack:** `new_game` and `move_valid` together in IDLE → grid=0, `turn`=0, `redraw_req`=1, move not accepted. Ack held high for 5 cycles → exactly one REDRAW exit.
